// File: rtl/sync_ram_pkg.sv
// rtl/sync_ram_pkg.sv - shared types and constants for the sync RAM burst master
// Contents: FSM state encoding, default widths, read skid FIFO sizing.

package sync_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_LEN_WIDTH  = 4;

    // Two entries cover the one-cycle RAM read latency plus one stalled word.
    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/sync_ram_rd_skid.sv
// rtl/sync_ram_rd_skid.sv - 2-entry registered skid FIFO for RAM read data
// Ports: clk, rst (async, active high); push/push_data write side;
// pop consumes the head; count = occupancy; valid/data = registered head.

module sync_ram_rd_skid
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [SKID_CNT_W-1:0] count,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    // Slot 0 is always the head; slot 1 is only occupied when slot 0 is.
    logic                  vld0, vld1;
    logic [DATA_WIDTH-1:0] ent0, ent1;
    logic                  vld0_n, vld1_n;
    logic [DATA_WIDTH-1:0] ent0_n, ent1_n;

    always_comb begin
        vld0_n = vld0;
        vld1_n = vld1;
        ent0_n = ent0;
        ent1_n = ent1;
        // Pop first (shift down), then place the push in the first free slot,
        // so a simultaneous push and pop leaves the count unchanged.
        if (pop && vld0) begin
            vld0_n = vld1;
            ent0_n = ent1;
            vld1_n = 1'b0;
        end
        if (push) begin
            if (!vld0_n) begin
                vld0_n = 1'b1;
                ent0_n = push_data;
            end else if (!vld1_n) begin
                vld1_n = 1'b1;
                ent1_n = push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld0 <= 1'b0;
            vld1 <= 1'b0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            vld0 <= vld0_n;
            vld1 <= vld1_n;
            ent0 <= ent0_n;
            ent1 <= ent1_n;
        end
    end

    assign count = SKID_CNT_W'(vld0) + SKID_CNT_W'(vld1);
    assign valid = vld0;
    assign data  = ent0;

endmodule

// File: rtl/sync_ram_master.sv
// rtl/sync_ram_master.sv - burst read/write initiator for one single-port sync RAM
// Ports: clk, rst (async, active high); cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len
// burst command; wr_valid/wr_ready/wr_data write stream; rd_valid/rd_ready/rd_data
// read stream; busy; ram_we/ram_addr/ram_din/ram_dout RAM side (dout one cycle late).
// Option: SYNC_RAM_MASTER_BOUND_CHECK_EN adds cmd_err and rejects bursts that would
// run past the top address; without it addresses wrap modulo the RAM depth.

module sync_ram_master
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
`ifdef SYNC_RAM_MASTER_BOUND_CHECK_EN
    output logic                  cmd_err,
`endif
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   cur_addr, cur_addr_n;
    logic [LEN_WIDTH-1:0]    remaining, remaining_n;
    logic                    inflight;
    logic                    issue;
    logic                    cmd_ready_n;
    logic                    cmd_fire;
    logic                    range_err;
    logic                    pop;
    logic [SKID_CNT_W-1:0]   fifo_count;
    logic [SKID_CNT_W:0]     occ_after_pop;

    assign cmd_fire = (state == IDLE) && cmd_valid && cmd_ready;
    assign pop      = rd_valid && rd_ready;

    // Words already owed to the client once this cycle's pop is taken out;
    // a new read may only be launched if its data is guaranteed a FIFO slot.
    assign occ_after_pop = (SKID_CNT_W + 1)'(fifo_count)
                         + (SKID_CNT_W + 1)'(inflight)
                         - (SKID_CNT_W + 1)'(pop);

`ifdef SYNC_RAM_MASTER_BOUND_CHECK_EN
    localparam int SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
    logic [SUM_W-1:0] end_addr;
    assign end_addr  = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign range_err = cmd_fire && (end_addr > SUM_W'((1 << ADDR_WIDTH) - 1));
`else
    assign range_err = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        cur_addr_n  = cur_addr;
        remaining_n = remaining;
        issue       = 1'b0;
        wr_ready    = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;

        case (state)
            IDLE: begin
                if (cmd_fire && !range_err) begin
                    cur_addr_n  = cmd_addr;
                    remaining_n = cmd_len;
                    state_n     = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                // Write data goes straight to the RAM in the accepting cycle.
                if (wr_valid) begin
                    ram_we      = 1'b1;
                    ram_addr    = cur_addr;
                    ram_din     = wr_data;
                    cur_addr_n  = cur_addr + ADDR_WIDTH'(1);
                    remaining_n = remaining - LEN_WIDTH'(1);
                    if (remaining == '0) begin
                        state_n = IDLE;
                    end
                end
            end
            READ: begin
                if (occ_after_pop < (SKID_CNT_W + 1)'(SKID_DEPTH)) begin
                    issue       = 1'b1;
                    ram_addr    = cur_addr;
                    cur_addr_n  = cur_addr + ADDR_WIDTH'(1);
                    remaining_n = remaining - LEN_WIDTH'(1);
                    if (remaining == '0) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight && (fifo_count == '0)) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Only offer a new command once no read data is owed to the client.
        cmd_ready_n = (state_n == IDLE) && !inflight && (fifo_count == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            cmd_ready <= 1'b0;
`ifdef SYNC_RAM_MASTER_BOUND_CHECK_EN
            cmd_err   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cur_addr  <= cur_addr_n;
            remaining <= remaining_n;
            inflight  <= issue;
            cmd_ready <= cmd_ready_n;
`ifdef SYNC_RAM_MASTER_BOUND_CHECK_EN
            cmd_err   <= range_err;
`endif
        end
    end

    // The RAM presents data the cycle after the address, which is exactly
    // when the in-flight flag is set for that read.
    sync_ram_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (ram_dout),
        .pop       (pop),
        .count     (fifo_count),
        .valid     (rd_valid),
        .data      (rd_data)
    );

    assign busy = (state != IDLE) || inflight || (fifo_count != '0);

endmodule

// File: tb/tb_sync_ram_master.sv
// tb/tb_sync_ram_master.sv - randomized self-checking bench for sync_ram_master

module tb_sync_ram_master;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int LW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef SYNC_RAM_MASTER_BOUND_CHECK_EN
    logic          cmd_err;
`endif

    sync_ram_master #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
`ifdef SYNC_RAM_MASTER_BOUND_CHECK_EN
        .cmd_err   (cmd_err),
`endif
        .ram_dout  (ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment: the synchronous RAM itself.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Reference model: what the memory should hold after each accepted burst.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wdata   [DEPTH];

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_rec_t;
    wr_rec_t wlog[$];
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ram_we === 1'b1) wlog.push_back('{int'(ram_addr), int'(ram_din), cyc});
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        check({tag, "_wr_ready"},  32'(wr_ready),  0);
        check({tag, "_rd_valid"},  32'(rd_valid),  0);
        check({tag, "_rd_data"},   32'(rd_data),   0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_ram_we"},    32'(ram_we),    0);
        check({tag, "_ram_addr"},  32'(ram_addr),  0);
        check({tag, "_ram_din"},   32'(ram_din),   0);
`ifdef SYNC_RAM_MASTER_BOUND_CHECK_EN
        check({tag, "_cmd_err"},   32'(cmd_err),   0);
`endif
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) wdata[i] = DW'($urandom_range(0, 255));
    endtask

    task automatic send_cmd(input logic wr, input int addr, input int len);
        int n;
        @(posedge clk); #1;
        cmd_write = wr;
        cmd_addr  = AW'(addr);
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_ready", 32'(cmd_ready), 1);
        check("idle_busy", 32'(busy), 0);
    endtask

    // gap_mode: 0 none, 1 single gap before the second beat, 2 random gaps
    task automatic do_write(input int addr, input int len, input int gap_mode);
        logic gap;
        wlog.delete();
        send_cmd(1'b1, addr, len);
        for (int i = 0; i <= len; i++) begin
            gap = (gap_mode == 1 && i == 1) || (gap_mode == 2 && $urandom_range(0, 3) == 0);
            if (gap) begin
                wr_valid = 1'b0;
                @(negedge clk);
                check("gap_no_we", 32'(ram_we), 0);
                @(posedge clk); #1;
            end
            wr_valid = 1'b1;
            wr_data  = wdata[i];
            @(negedge clk);
            check("wr_ready", 32'(wr_ready), 1);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check("wr_done_ready", 32'(cmd_ready), 1);
        check("wr_done_busy", 32'(busy), 0);
        check("wr_count", 32'(wlog.size()), 32'(len + 1));
        for (int i = 0; i <= len && i < wlog.size(); i++) begin
            check("wr_addr", 32'(wlog[i].addr), 32'((addr + i) % DEPTH));
            check("wr_data", 32'(wlog[i].data), 32'(wdata[i]));
            if (gap_mode == 0) check("wr_back_to_back", 32'(wlog[i].cyc), 32'(wlog[0].cyc + i));
        end
        for (int i = 0; i <= len; i++) ref_mem[(addr + i) % DEPTH] = wdata[i];
    endtask

    // mode: 0 rd_ready held high, 1 pattern 1,0,0 repeating, 2 random
    task automatic do_read(input int addr, input int len, input int mode);
        int            k;
        int            j;
        int            first;
        logic          stalled;
        logic [DW-1:0] held;
        wlog.delete();
        send_cmd(1'b0, addr, len);
        k = 0;
        j = 0;
        first = -1;
        stalled = 1'b0;
        held = '0;
        while (k <= len && j < 300) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ((j % 3) == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (rd_valid && first < 0) first = j;
            if (stalled) begin
                check("rd_hold_valid", 32'(rd_valid), 1);
                check("rd_hold_data", 32'(rd_data), 32'(held));
            end
            if (rd_valid && rd_ready) begin
                check("rd_data", 32'(rd_data), 32'(ref_mem[(addr + k) % DEPTH]));
                k++;
                stalled = 1'b0;
            end else if (rd_valid) begin
                stalled = 1'b1;
                held = rd_data;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
            j++;
        end
        rd_ready = 1'b0;
        check("rd_words", 32'(k), 32'(len + 1));
        check("rd_first_latency", 32'(first), 2);
        @(negedge clk);
        check("rd_no_extra", 32'(rd_valid), 0);
        wait_idle();
        check("rd_no_we", 32'(wlog.size()), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int addr;
        int len;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle();

        // Full-depth burst initialises every location.
        fill_random();
        do_write(0, DEPTH - 1, 0);

        // Directed burst A0..A3 at address 3, then read it back two ways.
        wdata[0] = 8'hA0; wdata[1] = 8'hA1; wdata[2] = 8'hA2; wdata[3] = 8'hA3;
        do_write(3, 3, 0);
        do_read(3, 3, 0);
        do_read(3, 3, 1);

`ifdef SYNC_RAM_MASTER_BOUND_CHECK_EN
        wlog.delete();
        send_cmd(1'b1, 14, 3);
        @(negedge clk);
        check("err_pulse", 32'(cmd_err), 1);
        check("err_no_wr_ready", 32'(wr_ready), 0);
        check("err_not_busy", 32'(busy), 0);
        @(negedge clk);
        check("err_pulse_end", 32'(cmd_err), 0);
        check("err_ready_again", 32'(cmd_ready), 1);
        check("err_no_we", 32'(wlog.size()), 0);
        do_write(15, 0, 0);
        do_read(15, 0, 0);
`else
        fill_random();
        do_write(14, 3, 0);
        do_read(14, 3, 2);
`endif

        // Gapped write: wr_valid 1,0,1,1.
        fill_random();
        do_write(0, 2, 1);
        do_read(0, 2, 0);

        // Reset in the middle of a write burst after two beats.
        fill_random();
        wlog.delete();
        send_cmd(1'b1, 5, 7);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = wdata[i];
            @(posedge clk); #1;
        end
        wr_data  = wdata[2];
        wr_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        wr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_wr_count", 32'(wlog.size()), 2);
        for (int i = 0; i < 2 && i < wlog.size(); i++) begin
            check("rst_mid_wr_addr", 32'(wlog[i].addr), 32'(5 + i));
            check("rst_mid_wr_data", 32'(wlog[i].data), 32'(wdata[i]));
        end
        ref_mem[5] = wdata[0];
        ref_mem[6] = wdata[1];
        wait_idle();
        do_read(4, 3, 0);

        // Randomized mix of bursts.
        for (int t = 0; t < 24; t++) begin
            addr = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, DEPTH - 1);
`ifdef SYNC_RAM_MASTER_BOUND_CHECK_EN
            if (addr + len > DEPTH - 1) len = DEPTH - 1 - addr;
`endif
            if ($urandom_range(0, 1) == 1) begin
                fill_random();
                do_write(addr, len, 2);
            end else begin
                do_read(addr, len, $urandom_range(0, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sync_ram_master.md
Name: sync_ram_master

Overview:
- Initiator for the team's single-port synchronous RAM. The RAM writes on `we`, and registers `dout` one cycle after the address is presented.
- Accepts burst read/write commands over a valid/ready interface and streams write data in.
- Returns read data out with backpressure.
- Sits between a client (DMA/CPU shim) and one sync RAM instance.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH.
- LEN_WIDTH, 4, burst length field width; burst = cmd_len+1 words (1..2**LEN_WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  words minus one.
- wr_valid  in  1  write data valid.
- wr_ready  out  1  write data accepted.
- wr_data  in  DATA_WIDTH  write word.
- rd_valid  out  1  read data valid.
- rd_ready  in  1  client accepts read word.
- rd_data  out  DATA_WIDTH  read word.
- busy  out  1  burst in progress or read data pending.
- ram_we  out  1  to RAM `we`.
- ram_addr  out  ADDR_WIDTH  to RAM `addr`.
- ram_din  out  DATA_WIDTH  to RAM `din`.
- ram_dout  in  DATA_WIDTH  from RAM `dout`; valid one cycle after address.

Behaviour:
- Reset values (async, all regs): state=IDLE, cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, ram_we=0, ram_addr=0, ram_din=0; skid FIFO empty, in-flight=0.
- **IDLE:**
  - cmd_ready=1 only when the read FIFO is empty and in-flight=0.
  - On handshake, latch addr, remaining=cmd_len and dir, then go to WRITE or READ.
  - cmd_ready is registered-low in all other states.
- **WRITE:**
  - wr_ready=1 combinationally.
  - Each wr_valid&wr_ready cycle drives ram_we=1, ram_addr=cur_addr, ram_din=wr_data in the same cycle (combinational pass-through to RAM).
  - Each such cycle increments addr and decrements remaining.
  - The last word (remaining==0) returns to IDLE the next cycle.
  - A wr_valid gap inserts an idle cycle with ram_we=0.
- **READ:**
  - ram_we=0. A read is issued (ram_addr=cur_addr) when fifo_count + inflight - pop < 2, where pop = rd_valid & rd_ready this cycle.
  - Issued reads set inflight=1; the next cycle ram_dout is pushed into a 2-entry skid FIFO.
  - Sustains 1 word/cycle when rd_ready is held high.
  - After the last issue, go to DRAIN.
- **DRAIN:**
  - Wait until in-flight=0 and the FIFO is empty, then go to IDLE.
  - busy stays 1 through DRAIN.
- **Read output:**
  - rd_valid/rd_data come from the FIFO head, registered.
  - Data order equals address order.
  - rd_data is held stable while rd_valid & !rd_ready.
- **Addressing:**
  - cur_addr increments modulo 2**ADDR_WIDTH; the wrap from max to 0 is legal when the feature below is off.
  - remaining is LEN_WIDTH bits; no overflow is possible.
- busy = (state != IDLE) | inflight | (fifo_count != 0).
- **Simultaneous events:**
  - FIFO push and pop in the same cycle keep the count.
  - A new command cannot be accepted while read data is pending.
- **Mid-burst reset:** everything returns to its reset value; the partial burst is abandoned; no RAM write occurs after rst asserts.

Optional Feature:
- Macro SYNC_RAM_MASTER_BOUND_CHECK_EN.
- **Defined:**
  - Adds output `cmd_err` (1 bit, reset 0).
  - In IDLE, a command with cmd_addr + cmd_len > 2**ADDR_WIDTH-1 is handshaken, but no RAM access occurs and no wr_ready is given.
  - cmd_err pulses 1 for one cycle the cycle after acceptance; state stays IDLE.
- **Undefined:** no cmd_err port; addresses wrap modulo depth.

Decomposition:
- Package sync_ram_pkg:
  - State enum (IDLE, WRITE, READ, DRAIN).
  - Default width localparams.
  - Skid FIFO depth constant = 2.
- One sub-module, sync_ram_rd_skid: 2-entry registered skid FIFO with push, pop, count, valid/data.
- The FSM and address/length counters stay in the top.

Test Plan:
- Write burst addr=3, len=3, data A0,A1,A2,A3 with wr_valid constant → ram_we high 4 consecutive cycles at addr 3,4,5,6; then back to IDLE; cmd_ready=1 the cycle after.
- Read back addr=3, len=3, rd_ready=1 → rd_data A0..A3 on 4 consecutive cycles; the first rd_valid comes 2 cycles after the command handshake.
- Same read with rd_ready toggled 1,0,0,1,… → no lost or duplicated words; rd_data stable while stalled; no more than 2 reads outstanding.
- Wrap: write addr=14, len=3 (macro off) → writes to 14,15,0,1. With the macro on → cmd_err pulse, no ram_we.
- Assert rst during a write burst after 2 words → ram_we=0 immediately; all outputs at reset values; next command proceeds normally.
- Gapped wr_valid (1,0,1,1) during len=2 write → ram_we follows accepted beats only; addresses 0,1,2 in order.
